bcd_disp_sched: RTL

BCD_DISP_SCHED -- requirements
Module: bcd_disp_sched

---
 rtl/bcd_disp_sched.sv | 82 ++++++++
 1 files changed

// File: rtl/bcd_disp_sched.sv
// bcd_disp_sched: round-robin scheduler sharing one binary-to-BCD converter among 4 requesters,
// with a timeout on the converter and a registered display result.
module bcd_disp_sched #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic [3:0]  i_req,
  input  logic [31:0] i_val,
  output logic        o_conv_start,
  output logic [7:0]  o_conv_din,
  input  logic        i_conv_done,
  input  logic [11:0] i_conv_bcd,
  output logic [3:0]  o_ack,
  output logic [11:0] o_disp_bcd,
  output logic [1:0]  o_disp_src,
  output logic        o_disp_valid,
  output logic        o_err
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, ACK} state_t;
  state_t      r_state;
  logic [1:0]  r_ptr, r_gnt, w_gnt;
  logic [7:0]  r_timer;
  logic [11:0] r_res;
  logic        w_expire, w_bad;
  // downward scan so the lowest offset from r_ptr wins
  always_comb begin
    w_gnt = r_ptr;
    for (int i = 3; i >= 0; i--)
      if (i_req[r_ptr + 2'(i)]) w_gnt = r_ptr + 2'(i);
  end
  assign w_expire = r_timer == 8'(TIMEOUT - 1);
  assign w_bad = (i_conv_bcd[11:8] > 4'd9) | (i_conv_bcd[7:4] > 4'd9) | (i_conv_bcd[3:0] > 4'd9);
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_timer      <= '0;
      r_res        <= '0;
      o_conv_start <= 1'b0;
      o_conv_din   <= '0;
      o_ack        <= '0;
      o_disp_bcd   <= '0;
      o_disp_src   <= '0;
      o_disp_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_conv_start <= 1'b0;
      o_ack        <= '0;
      case (r_state)
        IDLE: if (|i_req) begin
          r_gnt        <= w_gnt;
          o_conv_din   <= i_val[{w_gnt, 3'b000} +: 8];
          o_conv_start <= 1'b1;
          r_state      <= LOAD;
        end
        LOAD: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= r_timer + 8'd1;
          // done beats a coincident expiry
          if (i_conv_done | w_expire) begin
            r_res   <= i_conv_done ? i_conv_bcd : 12'hFFF;
            o_err   <= o_err | ~i_conv_done | w_bad;
            o_ack   <= 4'b0001 << r_gnt;
            r_state <= ACK;
          end
        end
        default: begin
          o_disp_bcd   <= r_res;
          o_disp_src   <= r_gnt;
          o_disp_valid <= 1'b1;
          r_ptr        <= r_gnt + 2'd1;
          r_state      <= IDLE;
        end
      endcase
    end
  end
endmodule
